// File: rtl/hex_count_source.sv
// Multi-digit hex/BCD counter advanced by a selectable rate divider; HEX_COUNT_BCD_EN selects BCD digits.
// Latency: digits/tick/wrap registered, tick and wrap coincide with the updated count; no backpressure.
module hex_count_source #(
  parameter int DIGITS = 4,
  parameter int RATE1  = 50000000,
  parameter int RATE2  = 25000000,
  parameter int RATE3  = 12500000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            speed,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  tick,
  output logic                  wrap
);

  localparam int W    = 4 * DIGITS;
  localparam int MAXR = (RATE1 > RATE2) ? ((RATE1 > RATE3) ? RATE1 : RATE3)
                                        : ((RATE2 > RATE3) ? RATE2 : RATE3);
  localparam int DW   = $clog2(MAXR);

  logic [DW-1:0] div_q;
  logic [DW-1:0] reload;
  logic [1:0]    speed_q;
  logic          speed_chg;
  logic          div_zero;
  logic          advance;
  logic [W-1:0]  next_count;
  logic          next_wrap;

  always_comb begin
    reload = '0;
    case (speed)
      2'b01:   reload = DW'(RATE1 - 1);
      2'b10:   reload = DW'(RATE2 - 1);
      2'b11:   reload = DW'(RATE3 - 1);
      default: reload = '0;
    endcase
  end

  // A speed change spends its edge reloading the divider instead of advancing.
  assign speed_chg = (speed != speed_q);
  assign div_zero  = (div_q == '0);
  assign advance   = enable & div_zero & ~speed_chg;

`ifdef HEX_COUNT_BCD_EN
  logic bcd_carry;

  // Any digit at 9 or above (loaded A..F) rolls to 0 and carries on.
  always_comb begin
    bcd_carry  = 1'b1;
    next_count = digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_carry) begin
        if (digits[4*k +: 4] >= 4'd9) begin
          next_count[4*k +: 4] = 4'd0;
        end else begin
          next_count[4*k +: 4] = digits[4*k +: 4] + 4'd1;
          bcd_carry            = 1'b0;
        end
      end
    end
    next_wrap = bcd_carry;
  end
`else
  assign {next_wrap, next_count} = {1'b0, digits} + (W+1)'(1);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits  <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      div_q   <= '0;
      speed_q <= 2'b00;
    end else begin
      speed_q <= speed;
      if (clear) begin
        digits <= '0;
        div_q  <= '0;
        tick   <= 1'b0;
        wrap   <= 1'b0;
      end else if (load) begin
        digits <= load_value;
        div_q  <= '0;
        tick   <= 1'b0;
        wrap   <= 1'b0;
      end else begin
        tick <= advance;
        wrap <= advance & next_wrap;
        if (advance) begin
          digits <= next_count;
        end
        if (speed_chg) begin
          div_q <= reload;
        end else if (enable) begin
          div_q <= div_zero ? reload : (div_q - DW'(1));
        end
      end
    end
  end

endmodule
